// File: rtl/fifo36_demux4.sv
// Routes 36-bit packet lines (bit 32 SOF, bit 33 EOF) to one of four outputs chosen by header match.
// Define FIFO36_DEMUX4_STATS_EN to add saturating per-channel packet and drop counters.
module fifo36_demux4 #(
    parameter logic [35:0] MATCH0_DATA    = 36'h0,
    parameter logic [35:0] MATCH0_MASK    = 36'h0,
    parameter logic [35:0] MATCH1_DATA    = 36'h0,
    parameter logic [35:0] MATCH1_MASK    = 36'h0,
    parameter logic [35:0] MATCH2_DATA    = 36'h0,
    parameter logic [35:0] MATCH2_MASK    = 36'h0,
    parameter int unsigned DEFAULT_CH     = 3,
    parameter bit          DROP_UNMATCHED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [35:0] data_i,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic [35:0] data_o,
    output logic [3:0]  src_rdy_o,
    input  logic [3:0]  dst_rdy_i,
    output logic        busy_o,
    output logic [63:0] pkt_count_o,
    output logic [15:0] drop_count_o
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ROUTE = 2'b01;
    localparam logic [1:0] DROP  = 2'b10;

    localparam logic [1:0] DEFAULT_SEL = DEFAULT_CH[1:0];

    logic [1:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       hit0, hit1, hit2;
    logic       lineXfer;

    // A zero mask disables a channel so an unconfigured channel never matches everything.
    always_comb begin
        hit0 = (MATCH0_MASK != 36'h0) && (((data_i ^ MATCH0_DATA) & MATCH0_MASK) == 36'h0);
        hit1 = (MATCH1_MASK != 36'h0) && (((data_i ^ MATCH1_DATA) & MATCH1_MASK) == 36'h0);
        hit2 = (MATCH2_MASK != 36'h0) && (((data_i ^ MATCH2_DATA) & MATCH2_MASK) == 36'h0);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dst_rdy_o = 1'b0;
        src_rdy_o = 4'b0000;
        case (state_q)
            IDLE: begin
                if (src_rdy_i) begin
                    state_d = ROUTE;
                    if (hit0) begin
                        sel_d = 2'd0;
                    end else if (hit1) begin
                        sel_d = 2'd1;
                    end else if (hit2) begin
                        sel_d = 2'd2;
                    end else begin
                        sel_d = DEFAULT_SEL;
                        if (DROP_UNMATCHED) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            ROUTE: begin
                src_rdy_o = {3'b000, src_rdy_i} << sel_q;
                dst_rdy_o = dst_rdy_i[sel_q];
                if (src_rdy_i && dst_rdy_i[sel_q] && data_i[33]) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                dst_rdy_o = 1'b1;
                if (src_rdy_i && data_i[33]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign lineXfer = src_rdy_i && dst_rdy_o;
    assign data_o   = data_i;
    assign busy_o   = (state_q != IDLE);

`ifdef FIFO36_DEMUX4_STATS_EN
    logic [3:0][15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    // Counters survive clear so a flush does not lose statistics.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (lineXfer && data_i[33]) begin
            if (state_q == ROUTE && pkt_cnt_q[sel_q] != 16'hFFFF) begin
                pkt_cnt_d[sel_q] = pkt_cnt_q[sel_q] + 16'd1;
            end
            if (state_q == DROP && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= 16'h0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count_o  = pkt_cnt_q;
    assign drop_count_o = drop_cnt_q;
`else
    logic unusedXfer;
    assign unusedXfer   = lineXfer;
    assign pkt_count_o  = 64'h0;
    assign drop_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_fifo36_demux4.sv
// Directed bench for fifo36_demux4: one routing instance and one drop-unmatched instance.
// Counter expectations follow FIFO36_DEMUX4_STATS_EN (zero when undefined).
module tb_fifo36_demux4;

    localparam logic [35:0] SOF = 36'h1_0000_0000;
    localparam logic [35:0] EOF = 36'h2_0000_0000;
    localparam logic [35:0] H0  = 36'h0_0000_1000;
    localparam logic [35:0] H1  = 36'h0_0000_00AB;
    localparam logic [35:0] H2  = 36'h0_0001_0000;
    localparam logic [35:0] H02 = 36'h0_0001_1000;
    localparam logic [35:0] HU  = 36'h0_0000_0055;
    localparam logic [35:0] D1  = 36'h0_1234_5678;
    localparam logic [35:0] D2  = 36'h0_0000_1000;
    localparam logic [35:0] D3  = 36'h0_9ABC_DEF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [35:0] dataIn = 36'h0;
    logic        srcRdy = 1'b0;
    logic        srcRdyB = 1'b0;
    logic [3:0]  dstRdy = 4'hF;

    logic        dstRdyO, dstRdyOB;
    logic [35:0] dataOut, dataOutB;
    logic [3:0]  srcRdyO, srcRdyOB;
    logic        busy, busyB;
    logic [63:0] pktCount, pktCountB;
    logic [15:0] dropCount, dropCountB;

    int checksTotal = 0;
    int checksPassed = 0;
    int ch3Count = 0;
    logic [35:0] ch3Log [8];

    always #5 clk = ~clk;

    fifo36_demux4 #(
        .MATCH0_DATA(H0), .MATCH0_MASK(36'h0_0000_F000),
        .MATCH1_DATA(H1), .MATCH1_MASK(36'h0_0000_00FF),
        .MATCH2_DATA(H2), .MATCH2_MASK(36'h0_000F_0000),
        .DEFAULT_CH(3), .DROP_UNMATCHED(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .data_i(dataIn), .src_rdy_i(srcRdy), .dst_rdy_o(dstRdyO),
        .data_o(dataOut), .src_rdy_o(srcRdyO), .dst_rdy_i(dstRdy),
        .busy_o(busy), .pkt_count_o(pktCount), .drop_count_o(dropCount)
    );

    fifo36_demux4 #(
        .MATCH0_DATA(H0), .MATCH0_MASK(36'h0_0000_F000),
        .MATCH1_DATA(H1), .MATCH1_MASK(36'h0_0000_00FF),
        .MATCH2_DATA(H2), .MATCH2_MASK(36'h0_000F_0000),
        .DEFAULT_CH(3), .DROP_UNMATCHED(1'b1)
    ) dutDrop (
        .clk(clk), .reset(reset), .clear(clear),
        .data_i(dataIn), .src_rdy_i(srcRdyB), .dst_rdy_o(dstRdyOB),
        .data_o(dataOutB), .src_rdy_o(srcRdyOB), .dst_rdy_i(dstRdy),
        .busy_o(busyB), .pkt_count_o(pktCountB), .drop_count_o(dropCountB)
    );

    // Log every line handed to channel 3 so loss or duplication shows up.
    always @(posedge clk) begin
        if (!reset && !clear && srcRdyO[3] && dstRdy[3]) begin
            if (ch3Count < 8) ch3Log[ch3Count] <= dataOut;
            ch3Count <= ch3Count + 1;
        end
    end

    function automatic logic [63:0] expCnt(input logic [63:0] v);
`ifdef FIFO36_DEMUX4_STATS_EN
        return v;
`else
        return 64'h0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sB, input logic [35:0] d, input logic [3:0] dr);
        @(negedge clk);
        srcRdy  = s;
        srcRdyB = sB;
        dataIn  = d;
        dstRdy  = dr;
        #1;
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_srcrdy", srcRdyO, 0);
        checkOutput("rst_dstrdy", dstRdyO, 0);
        checkOutput("rst_busyB", busyB, 0);
        checkOutput("rst_pkt", pktCount, 0);
        checkOutput("rst_drop", dropCountB, 0);

        // Back-to-back single-line packets to channels 0, 1, 2
        applyStimulus(1'b1, 1'b0, SOF | EOF | H0, 4'hF);
        checkOutput("b2b_idle0", srcRdyO, 0);
        checkOutput("b2b_idle0_dst", dstRdyO, 0);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H0, 4'hF);
        checkOutput("b2b_ch0", srcRdyO, 4'b0001);
        checkOutput("b2b_ch0_dst", dstRdyO, 1);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H1, 4'hF);
        checkOutput("b2b_idle1", busy, 0);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H1, 4'hF);
        checkOutput("b2b_ch1", srcRdyO, 4'b0010);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H2, 4'hF);
        checkOutput("b2b_idle2", busy, 0);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H2, 4'hF);
        checkOutput("b2b_ch2", srcRdyO, 4'b0100);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("b2b_done", busy, 0);
        checkOutput("b2b_pkt", pktCount, expCnt(64'h0000_0001_0001_0001));

        // Three-line packet to channel 1; last line would match channel 0
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        checkOutput("c1_idle", srcRdyO, 0);
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        checkOutput("c1_l0", srcRdyO, 4'b0010);
        checkOutput("c1_data", dataOut, SOF | H1);
        applyStimulus(1'b1, 1'b0, D1, 4'hF);
        checkOutput("c1_l1", srcRdyO, 4'b0010);
        applyStimulus(1'b1, 1'b0, EOF | D2, 4'hF);
        checkOutput("c1_l2", srcRdyO, 4'b0010);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("c1_busy", busy, 0);
        checkOutput("c1_after", srcRdyO, 0);
        checkOutput("c1_pkt", pktCount, expCnt(64'h0000_0001_0002_0001));

        // Header matching channels 0 and 2 goes to channel 0
        applyStimulus(1'b1, 1'b0, SOF | EOF | H02, 4'hF);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H02, 4'hF);
        checkOutput("prio_ch0", srcRdyO, 4'b0001);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("prio_busy", busy, 0);
        checkOutput("prio_pkt", pktCount, expCnt(64'h0000_0001_0002_0002));

        // Unmatched header to default channel 3 with throttled dst_rdy
        applyStimulus(1'b1, 1'b0, SOF | HU, 4'b1000);
        applyStimulus(1'b1, 1'b0, SOF | HU, 4'b1000);
        checkOutput("def_sr0", srcRdyO, 4'b1000);
        checkOutput("def_dr0", dstRdyO, 1);
        applyStimulus(1'b1, 1'b0, D1, 4'b0111);
        checkOutput("def_sr1", srcRdyO, 4'b1000);
        checkOutput("def_dr1", dstRdyO, 0);
        applyStimulus(1'b1, 1'b0, D1, 4'b1000);
        checkOutput("def_dr2", dstRdyO, 1);
        applyStimulus(1'b1, 1'b0, EOF | D2, 4'b0111);
        checkOutput("def_dr3", dstRdyO, 0);
        checkOutput("def_busy3", busy, 1);
        applyStimulus(1'b1, 1'b0, EOF | D2, 4'b1000);
        checkOutput("def_dr4", dstRdyO, 1);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("def_busy", busy, 0);
        checkOutput("def_n", ch3Count, 3);
        checkOutput("def_line0", ch3Log[0], SOF | HU);
        checkOutput("def_line1", ch3Log[1], D1);
        checkOutput("def_line2", ch3Log[2], EOF | D2);
        checkOutput("def_pkt", pktCount, expCnt(64'h0001_0001_0002_0002));

        // Unmatched four-line packet dropped by the second instance
        applyStimulus(1'b0, 1'b1, SOF | HU, 4'h0);
        checkOutput("drop_idle", dstRdyOB, 0);
        applyStimulus(1'b0, 1'b1, SOF | HU, 4'h0);
        checkOutput("drop_sr0", srcRdyOB, 0);
        checkOutput("drop_dr0", dstRdyOB, 1);
        applyStimulus(1'b0, 1'b1, D1, 4'h0);
        checkOutput("drop_dr1", dstRdyOB, 1);
        applyStimulus(1'b0, 1'b1, D2, 4'h0);
        checkOutput("drop_dr2", dstRdyOB, 1);
        checkOutput("drop_data", dataOutB, D2);
        applyStimulus(1'b0, 1'b1, EOF | D3, 4'h0);
        checkOutput("drop_sr3", srcRdyOB, 0);
        checkOutput("drop_dr3", dstRdyOB, 1);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("drop_busy", busyB, 0);
        checkOutput("drop_cnt", dropCountB, expCnt(64'h1));
        checkOutput("drop_pktB", pktCountB, 0);

        // Reset on the second line of a five-line packet
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        checkOutput("rmid_l0", srcRdyO, 4'b0010);
        applyStimulus(1'b1, 1'b0, D1, 4'hF);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, SOF | EOF | H0, 4'hF);
        reset = 1'b0;
        checkOutput("rmid_busy", busy, 0);
        checkOutput("rmid_sr", srcRdyO, 0);
        checkOutput("rmid_pkt", pktCount, 0);
        checkOutput("rmid_drop", dropCountB, 0);
        applyStimulus(1'b1, 1'b0, SOF | EOF | H0, 4'hF);
        checkOutput("rmid_new", srcRdyO, 4'b0001);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("rmid_pkt2", pktCount, expCnt(64'h0000_0000_0000_0001));

        // Clear on the second line keeps counters
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        applyStimulus(1'b1, 1'b0, SOF | H1, 4'hF);
        applyStimulus(1'b1, 1'b0, D1, 4'hF);
        clear = 1'b1;
        applyStimulus(1'b1, 1'b0, SOF | EOF | H2, 4'hF);
        clear = 1'b0;
        checkOutput("cmid_busy", busy, 0);
        checkOutput("cmid_dst", dstRdyO, 0);
        checkOutput("cmid_pkt", pktCount, expCnt(64'h0000_0000_0000_0001));
        applyStimulus(1'b1, 1'b0, SOF | EOF | H2, 4'hF);
        checkOutput("cmid_new", srcRdyO, 4'b0100);
        applyStimulus(1'b0, 1'b0, 36'h0, 4'hF);
        checkOutput("cmid_pkt2", pktCount, expCnt(64'h0000_0001_0000_0001));

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
